// File: rtl/pwm_update_sched_if.sv
// Configuration/event/active-register bundle between the PWM register block and the
// update scheduler.
interface pwm_update_sched_if #(
   parameter int unsigned PWM_WIDTH      = 8,
   parameter int unsigned PWMCOUNT_WIDTH = 16,
   parameter int unsigned EVTCOUNT_WIDTH = 3
) ();
   logic                                  cfg_wr;
   logic [PWMCOUNT_WIDTH-1:0]             cfg_period;
   logic [PWM_WIDTH*PWMCOUNT_WIDTH-1:0]   cfg_compare;
   logic [1:0]                            cfg_count_mode;
   logic [1:0]                            cfg_mask_mode;
   logic [EVTCOUNT_WIDTH-1:0]             cfg_evt_prescale;
   logic                                  cfg_pwm_on;
   logic                                  force_upd;
   logic                                  evt_min;
   logic                                  evt_max;
   logic                                  int_en;
   logic                                  int_ack;
   logic [PWMCOUNT_WIDTH-1:0]             act_period;
   logic [PWM_WIDTH*PWMCOUNT_WIDTH-1:0]   act_compare;
   logic [1:0]                            act_count_mode;
   logic                                  act_pwm_on;
   logic                                  upd_pulse;
   logic                                  pending;
   logic                                  int_req;

   modport master (
      output cfg_wr, cfg_period, cfg_compare, cfg_count_mode, cfg_mask_mode,
             cfg_evt_prescale, cfg_pwm_on, force_upd, evt_min, evt_max, int_en, int_ack,
      input  act_period, act_compare, act_count_mode, act_pwm_on, upd_pulse, pending, int_req
   );

   modport slave (
      input  cfg_wr, cfg_period, cfg_compare, cfg_count_mode, cfg_mask_mode,
             cfg_evt_prescale, cfg_pwm_on, force_upd, evt_min, evt_max, int_en, int_ack,
      output act_period, act_compare, act_count_mode, act_pwm_on, upd_pulse, pending, int_req
   );
endinterface

// File: rtl/pwm_update_sched.sv
// Shadow-register update scheduler: captures a PWM configuration set and commits it
// atomically on a qualified, prescaled carrier event.
module pwm_update_sched #(
   parameter int unsigned PWM_WIDTH      = 8,
   parameter int unsigned PWMCOUNT_WIDTH = 16,
   parameter int unsigned EVTCOUNT_WIDTH = 3
) (
   input logic              clk,
   input logic              rst_n,
   pwm_update_sched_if.slave bus
);
   localparam int unsigned CmpW = PWM_WIDTH * PWMCOUNT_WIDTH;

   typedef enum logic [0:0] {StIdle, StArmed} state_e;

   state_e                    r_state, w_state_d;
   logic [PWMCOUNT_WIDTH-1:0] r_sh_period, w_sh_period_d;
   logic [CmpW-1:0]           r_sh_compare, w_sh_compare_d;
   logic [1:0]                r_sh_mode, w_sh_mode_d;
   logic [1:0]                r_sh_mask, w_sh_mask_d;
   logic [EVTCOUNT_WIDTH-1:0] r_sh_prescale, w_sh_prescale_d;
   logic                      r_sh_on, w_sh_on_d;
   logic [EVTCOUNT_WIDTH-1:0] r_evt_cnt, w_evt_cnt_d;
   logic [PWMCOUNT_WIDTH-1:0] r_act_period, w_act_period_d;
   logic [CmpW-1:0]           r_act_compare, w_act_compare_d;
   logic [1:0]                r_act_mode, w_act_mode_d;
   logic                      r_act_on, w_act_on_d;
   logic                      r_upd_pulse, w_upd_pulse_d;
   logic                      r_int_req, w_int_req_d;
   logic                      w_qual;
   logic                      w_commit;

   // Simultaneous min and max collapse into a single event.
   assign w_qual   = (bus.evt_min & ~r_sh_mask[0]) | (bus.evt_max & ~r_sh_mask[1]);
   assign w_commit = (r_state == StArmed) &&
                     (bus.force_upd || !r_act_on || (w_qual && (r_evt_cnt == r_sh_prescale)));

   always_comb begin
      w_state_d       = r_state;
      w_sh_period_d   = r_sh_period;
      w_sh_compare_d  = r_sh_compare;
      w_sh_mode_d     = r_sh_mode;
      w_sh_mask_d     = r_sh_mask;
      w_sh_prescale_d = r_sh_prescale;
      w_sh_on_d       = r_sh_on;
      w_evt_cnt_d     = r_evt_cnt;
      w_act_period_d  = r_act_period;
      w_act_compare_d = r_act_compare;
      w_act_mode_d    = r_act_mode;
      w_act_on_d      = r_act_on;
      w_upd_pulse_d   = 1'b0;
      w_int_req_d     = r_int_req & ~bus.int_ack;

      if (w_commit) begin
         w_act_period_d  = r_sh_period;
         w_act_compare_d = r_sh_compare;
         w_act_mode_d    = r_sh_mode;
         w_act_on_d      = r_sh_on;
         w_upd_pulse_d   = 1'b1;
         w_evt_cnt_d     = '0;
         w_state_d       = StIdle;
         if (bus.int_en) w_int_req_d = 1'b1;
      end else if ((r_state == StArmed) && w_qual && (r_evt_cnt != '1)) begin
         w_evt_cnt_d = r_evt_cnt + {{(EVTCOUNT_WIDTH-1){1'b0}}, 1'b1};
      end

      // A write alongside a commit refills the shadow after the old set has left.
      if (bus.cfg_wr) begin
         w_sh_period_d   = bus.cfg_period;
         w_sh_compare_d  = bus.cfg_compare;
         w_sh_mode_d     = bus.cfg_count_mode;
         w_sh_mask_d     = bus.cfg_mask_mode;
         w_sh_prescale_d = bus.cfg_evt_prescale;
         w_sh_on_d       = bus.cfg_pwm_on;
         w_state_d       = StArmed;
         if ((r_state == StIdle) || w_commit) w_evt_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= StIdle;
         r_sh_period   <= '0;
         r_sh_compare  <= '0;
         r_sh_mode     <= '0;
         r_sh_mask     <= '0;
         r_sh_prescale <= '0;
         r_sh_on       <= 1'b0;
         r_evt_cnt     <= '0;
         r_act_period  <= '0;
         r_act_compare <= '0;
         r_act_mode    <= '0;
         r_act_on      <= 1'b0;
         r_upd_pulse   <= 1'b0;
         r_int_req     <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_sh_period   <= w_sh_period_d;
         r_sh_compare  <= w_sh_compare_d;
         r_sh_mode     <= w_sh_mode_d;
         r_sh_mask     <= w_sh_mask_d;
         r_sh_prescale <= w_sh_prescale_d;
         r_sh_on       <= w_sh_on_d;
         r_evt_cnt     <= w_evt_cnt_d;
         r_act_period  <= w_act_period_d;
         r_act_compare <= w_act_compare_d;
         r_act_mode    <= w_act_mode_d;
         r_act_on      <= w_act_on_d;
         r_upd_pulse   <= w_upd_pulse_d;
         r_int_req     <= w_int_req_d;
      end
   end

   assign bus.act_period     = r_act_period;
   assign bus.act_compare    = r_act_compare;
   assign bus.act_count_mode = r_act_mode;
   assign bus.act_pwm_on     = r_act_on;
   assign bus.upd_pulse      = r_upd_pulse;
   assign bus.pending        = (r_state == StArmed);
   assign bus.int_req        = r_int_req;
endmodule

// File: doc/pwm_update_sched.md
# pwm_update_sched

Shadow-register update scheduler for the 8-channel carrier PWM. It sits between the processor-side configuration registers and the carrier/compare datapath. It captures a new configuration set (period, per-channel compares, count mode, on/off) into a shadow bank. It then commits the set atomically to the active outputs on a qualified carrier event (min/max, masked, prescaled), so the datapath never sees a torn or mid-period update.

## Interface
- PWM_WIDTH, 8, number of PWM channels
- PWMCOUNT_WIDTH, 16, carrier period/compare width
- EVTCOUNT_WIDTH, 3, event prescaler width
- clk  in  1  single system clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_wr  in  1  one-cycle write strobe for shadow bank
- cfg_period  in  PWMCOUNT_WIDTH  new carrier period
- cfg_compare  in  PWM_WIDTH*PWMCOUNT_WIDTH  new compares, channel i at [i*W +: W]
- cfg_count_mode  in  2  _count_mode encoding (NO_COUNT=0, UP=1, DOWN=2, UPDOWN=3)
- cfg_mask_mode  in  2  _mask_mode encoding (NO_MASK=0, MIN_MASK=1, MAX_MASK=2, MINMAX_MASK=3)
- cfg_evt_prescale  in  EVTCOUNT_WIDTH  commit on the (N+1)th qualified event
- cfg_pwm_on  in  1  PWM_OFF=0 / PWM_ON=1
- force_upd  in  1  commit pending shadow next cycle, ignoring events
- evt_min, evt_max  in  1 each  single-cycle carrier min/max event pulses
- int_en  in  1  INT_OFF=0 / INT_ON=1
- int_ack  in  1  clears int_req
- act_period, act_compare, act_count_mode, act_pwm_on  out  same widths as cfg_*  active (committed) configuration
- upd_pulse  out  1  one-cycle pulse in the cycle active regs take new values
- pending  out  1  shadow holds an uncommitted set
- int_req  out  1  sticky update interrupt

## Operation
- States: IDLE (pending=0), ARMED (pending=1).
- IDLE + cfg_wr: load shadow (all cfg_* incl. mask, prescale), clear evt_cnt, go ARMED.
- ARMED + cfg_wr: overwrite shadow; evt_cnt not cleared; stay ARMED.
- Qualified event q = (evt_min & ~mask[0]) | (evt_max & ~mask[1]), using the shadow mask. evt_min and evt_max in the same cycle count as one event. MINMAX_MASK → no event ever qualifies; commit only via force_upd or the off-bypass.
- Commit condition in ARMED: force_upd, or act_pwm_on==PWM_OFF (carrier idle bypass), or (q and evt_cnt==shadow prescale). Otherwise q increments evt_cnt, saturating at all-ones.
- Commit: active regs ← shadow, upd_pulse=1, evt_cnt←0, go IDLE.
- Commit and cfg_wr in the same cycle: the old shadow commits. The new data loads into the shadow with evt_cnt=0 and the state stays ARMED.
- cfg_wr and force_upd in IDLE in the same cycle: write only; force ignored.
- int_req: set on commit when int_en=1; cleared on int_ack; set wins over a simultaneous ack.
- evt_* and force_upd ignored in IDLE.

## Timing
- Reset values: act_period=0, act_compare=0, act_count_mode=NO_COUNT, act_pwm_on=PWM_OFF, upd_pulse=0, pending=0, int_req=0; shadow and evt_cnt=0; state IDLE.
- cfg_wr at edge t → pending=1 after t.
- A commit decided in cycle t (qualified event/force sampled) → active regs and upd_pulse valid after edge t (1-cycle latency). upd_pulse is high for exactly one cycle.
- Off-bypass: cfg_wr at t while act_pwm_on=0 → commit in the following cycle (active after t+1).
- Reset asserted mid-ARMED: the pending set is discarded, and all outputs return to reset values asynchronously.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, cfg_wr (period=1000, cmp0=250, UPDOWN, on=1, NO_MASK, prescale=0) → committed one cycle later via off-bypass; upd_pulse once; pending 1→0.
- With act_pwm_on=1, write period=2000, prescale=2, MIN_MASK; pulse evt_min ×3 → no commit. Then evt_max ×3 → commit after the third evt_max, not before.
- MINMAX_MASK, events for 50 cycles → no commit; force_upd → active updates next cycle.
- Commit-cycle collision: qualifying evt_max together with cfg_wr(period=500) → active=old shadow; pending stays 1 with period 500; next qualified event commits 500.
- int_en=1: commit → int_req=1; int_ack coincident with the next commit → int_req remains 1; a lone ack → 0.
- rst_n low while ARMED with prescale=7 → all outputs reset immediately; post-reset events cause no commit.
